// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : fetch PC, one-in-flight imem reads, in-order instr queue   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        halted_o
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [AW:0]   c_full      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);
  localparam logic [29:0]   c_reset_wpc = RESET_PC[31:2];

  logic [29:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic          stop_q, stop_d;
  logic          halted_q, halted_d;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [29:0]   pc_mem_q   [DEPTH];

  logic          w_resp;
  logic          w_enq;
  logic          w_deq;
  logic [31:0]   w_head_inst;
  logic [29:0]   w_head_pc;
  logic          w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^redirect_pc_i[1:0];

  // A response only counts while a request is in flight; stray strobes are ignored.
  assign w_resp = imem_valid_i & outstanding_q;
  assign w_enq  = w_resp & ~drop_q & ~redirect_i;

  assign w_head_inst = inst_mem_q[rd_ptr_q];
  assign w_head_pc   = pc_mem_q[rd_ptr_q];

  assign inst_valid_o = (count_q != '0) & ~halted_q;
  assign w_deq        = inst_valid_o & inst_ready_i;
  assign inst_o       = inst_valid_o ? w_head_inst : 32'h0;
  assign inst_pc_o    = inst_valid_o ? {w_head_pc, 2'b00} : 32'h0;
  assign halted_o     = halted_q;

  assign imem_req_o  = reset_i & ~outstanding_q & ~stop_q & ~redirect_i
                     & ~halted_q & (count_q < c_full);
  assign imem_addr_o = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    stop_d        = stop_q;
    halted_d      = halted_q;

    // The consumer took the head even if a redirect flushes the rest.
    if (w_deq && (w_head_inst == 32'h0)) begin
      halted_d = 1'b1;
    end

    if (w_resp) begin
      outstanding_d = 1'b0;
    end

    if (redirect_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc_i[31:2];
      stop_d     = 1'b0;
      drop_d     = outstanding_q & ~imem_valid_i;
    end else begin
      if (w_resp && drop_q) begin
        drop_d = 1'b0;
      end
      if (w_enq) begin
        wr_ptr_d   = wr_ptr_q + c_ptr_one;
        fetch_pc_d = fetch_pc_q + 30'd1;
        if (imem_data_i == 32'h0) begin
          stop_d = 1'b1;
        end
      end
      if (w_deq) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
      if (imem_req_o) begin
        outstanding_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fetch_pc_q    <= c_reset_wpc;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      stop_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      stop_q        <= stop_d;
      halted_q      <= halted_d;
    end
  end

  // Storage needs no reset: it is never observed while count is zero.
  always_ff @(posedge clk_i) begin
    if (reset_i && w_enq) begin
      inst_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue : randomized + directed bench with queue-based ref model  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_valid_i (imem_valid),
    .imem_data_i  (imem_data),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_ready_i (inst_ready),
    .halted_o     (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch state as plain variables, queue as an SV queue.
  typedef struct packed {logic [31:0] pc; logic [31:0] w;} entry_t;
  typedef struct {int unsigned fire; logic [29:0] addr;} rsp_t;

  entry_t      mq[$];
  logic [29:0] m_fpc;
  bit          m_out, m_drop, m_stop, m_halt;

  logic [31:0] mem_w [256];
  rsp_t        rq[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;

  int          n_req;
  logic [31:0] acc_pc[$];
  bit          arm_first;
  logic [29:0] first_addr;

  task automatic model_reset();
    mq.delete();
    m_fpc  = RESET_PC[31:2];
    m_out  = 0;
    m_drop = 0;
    m_stop = 0;
    m_halt = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance model, clock.
  task automatic step(input bit rst_n, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          m_valid, m_req, resp, deq;
    logic [31:0] m_inst, m_pc;
    int unsigned fire;
    reset       = rst_n;
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    imem_valid  = 1'b0;
    imem_data   = $urandom();
    if (rq.size() > 0 && rq[0].fire <= cyc) begin
      imem_valid = 1'b1;
      imem_data  = mem_w[rq[0].addr[7:0]];
      void'(rq.pop_front());
    end
    #1;
    m_valid = (mq.size() != 0) && !m_halt;
    m_inst  = m_valid ? mq[0].w  : 32'h0;
    m_pc    = m_valid ? mq[0].pc : 32'h0;
    m_req   = rst_n && !m_out && !m_stop && !redir && !m_halt && (mq.size() < DEPTH);
    check_eq("imem_req",   imem_req,   m_req);
    check_eq("imem_addr",  imem_addr,  m_fpc);
    check_eq("inst_valid", inst_valid, m_valid);
    check_eq("inst",       inst,       m_inst);
    check_eq("inst_pc",    inst_pc,    m_pc);
    check_eq("halted",     halted,     m_halt);
    if (imem_req) n_req++;
    if (arm_first && imem_req) begin
      first_addr = imem_addr;
      arm_first  = 0;
    end
    if (rst_n && inst_valid && rdy) acc_pc.push_back(inst_pc);

    if (!rst_n) begin
      model_reset();
    end else begin
      deq  = m_valid && rdy;
      resp = imem_valid && m_out;
      if (deq) begin
        if (mq[0].w == 32'h0) m_halt = 1;
        void'(mq.pop_front());
      end
      if (resp) m_out = 0;
      if (redir) begin
        mq.delete();
        m_fpc  = rpc[31:2];
        m_stop = 0;
        m_drop = m_out;
      end else begin
        if (resp) begin
          if (m_drop) begin
            m_drop = 0;
          end else begin
            mq.push_back('{pc: {m_fpc, 2'b00}, w: imem_data});
            if (imem_data == 32'h0) m_stop = 1;
            m_fpc = m_fpc + 30'd1;
          end
        end
        if (m_req) begin
          m_out = 1;
          fire  = cyc + $urandom_range(lat_max, lat_min);
          if (rq.size() > 0 && rq[$].fire >= fire) fire = rq[$].fire + 1;
          rq.push_back('{fire: fire, addr: m_fpc});
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, rdy);
  endtask

  task automatic fill_mem_nonzero();
    for (int i = 0; i < 256; i++) mem_w[i] = $urandom() | 32'h1;
  endtask

  initial begin
    bit found;
    fill_mem_nonzero();
    model_reset();
    reset = 0; redirect = 0; redirect_pc = 0; inst_ready = 0; imem_valid = 0; imem_data = 0;
    n_req = 0; arm_first = 0; first_addr = '0;
    @(posedge clk);
    #1;

    // Reset state against fixed constants.
    step(0, 0, 32'h0, 1);
    check_eq("rst_req",   imem_req,   0);
    check_eq("rst_addr",  imem_addr,  RESET_PC[31:2]);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_inst",  inst,       0);
    check_eq("rst_pc",    inst_pc,    0);
    check_eq("rst_halt",  halted,     0);

    // Short program ending in the halt word.
    mem_w[0] = 32'h2002_0005;
    mem_w[1] = 32'h2003_0007;
    mem_w[2] = 32'h0000_0000;
    n_req = 0;
    acc_pc.delete();
    run(14, 1);
    check_eq("A_reqs",   n_req, 3);
    check_eq("A_halted", halted, 1);
    check_eq("A_nacc",   acc_pc.size(), 3);
    if (acc_pc.size() == 3) begin
      check_eq("A_pc0", acc_pc[0], 32'h0);
      check_eq("A_pc1", acc_pc[1], 32'h4);
      check_eq("A_pc2", acc_pc[2], 32'h8);
    end

    // Consumer stalled: queue fills to DEPTH, then drains in order.
    mem_w[2] = 32'h1234_5679;
    step(0, 0, 32'h0, 0);
    n_req = 0;
    run(16, 0);
    check_eq("B_reqs_full", n_req, DEPTH);
    acc_pc.delete();
    arm_first = 0;
    run(12, 1);
    check_eq("B_first_pc", (acc_pc.size() > 0) ? acc_pc[0] : 32'hFFFF_FFFF, 32'h0);

    // Redirect while a slow request is in flight.
    lat_min = 3; lat_max = 3;
    step(0, 0, 32'h0, 1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_out && m_fpc == 30'd2 && rq.size() > 0 && rq[0].fire > cyc) found = 1;
      else step(1, 0, 32'h0, 1);
    end
    check_eq("C_wait", found, 1);
    arm_first = 1;
    if (found) step(1, 1, 32'h0000_0043, 1);
    run(12, 1);
    check_eq("C_first_addr", first_addr, 30'h10);

    // Redirect in the same cycle as a response.
    lat_min = 1; lat_max = 1;
    step(0, 0, 32'h0, 1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_out && rq.size() > 0 && rq[0].fire <= cyc && m_fpc == 30'd3) found = 1;
      else step(1, 0, 32'h0, 1);
    end
    check_eq("D_wait", found, 1);
    if (found) step(1, 1, 32'h0000_0200, 1);
    check_eq("D_empty", inst_valid, 0);
    run(8, 1);

    // Zero word queued, then flushed by a redirect before it is consumed.
    mem_w[1] = 32'h0;
    step(0, 0, 32'h0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_stop) found = 1;
      else step(1, 0, 32'h0, 0);
    end
    check_eq("E_wait", found, 1);
    arm_first = 1;
    step(1, 1, 32'h0000_0100, 0);
    run(12, 1);
    check_eq("E_halted", halted, 0);
    check_eq("E_first_addr", first_addr, 30'h40);

    // Reset pulse while a slow request is outstanding.
    lat_min = 3; lat_max = 3;
    run(3, 1);
    step(0, 0, 32'h0, 1);
    run(12, 1);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 256; i++) mem_w[i] = ($urandom_range(23, 0) == 0) ? 32'h0 : ($urandom() | 32'h1);
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_red, r_rdy;
      r_rst = ($urandom_range(199, 0) != 0);
      r_red = ($urandom_range(32, 0) == 0);
      r_rdy = ($urandom_range(3, 0) != 0);
      step(r_rst, r_red, $urandom_range(1023, 0), r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly upstream of the single-cycle datapath `machine`. It owns the fetch PC, issues word reads to instruction memory, buffers returned words with their PCs in a small in-order queue, and presents them to the decode/execute stage through a valid/ready handshake. It also detects the all-zero halt word, stops fetching, and flags the halt to the simulation harness.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h00000000: byte address of the first fetch; bits [1:0] must be 0.

- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low: state is cleared on a posedge where `reset`==0.
- `imem_req`  out  1  one-cycle request pulse to instruction memory.
- `imem_addr`  out  30  word address (byte address [31:2]); held stable while a request is outstanding.
- `imem_valid`  in  1  response strobe; exactly one per request, at least 1 cycle after `imem_req`.
- `imem_data`  in  32  instruction word, valid with `imem_valid`.
- `redirect`  in  1  branch/jump taken: flush and refetch.
- `redirect_pc`  in  32  new byte PC; bits [1:0] ignored.
- `inst_valid`  out  1  head entry present.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  head byte PC, {word addr, 2'b00}.
- `inst_ready`  in  1  consumer accepts head this cycle.
- `halted`  out  1  sticky: halt word has been consumed.

## Operation
- State: `fetch_pc` (30 b), queue storage, rd/wr pointers, `count` (0..DEPTH), `outstanding` (0/1), `drop` (0/1), `stop` (0/1), `halted`.
- Reset: `fetch_pc`=RESET_PC[31:2], count=0, outstanding=0, drop=0, stop=0, halted=0; outputs `imem_req`=0, `imem_addr`=RESET_PC[31:2], `inst_valid`=0, `inst`=0, `inst_pc`=0, `halted`=0.
- Issue: `imem_req`=1 when !outstanding && !stop && !redirect && (count < DEPTH); `imem_addr`=`fetch_pc`. Next cycle outstanding=1. At most one request in flight.
- Response: on `imem_valid` with outstanding=1: outstanding→0. If drop=1, discard word, drop→0. Otherwise enqueue {fetch_pc, imem_data}, `fetch_pc`→`fetch_pc`+1 (wraps mod 2^30). If `imem_data`==0, stop→1.
- Space rule: a request is only issued when count<DEPTH, and count cannot grow while outstanding, so enqueue never hits a full queue.
- Dequeue: when `inst_valid` && `inst_ready`, pop head. If popped `inst`==0, halted→1 (sticky until reset).
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
- Redirect (highest priority): queue flushed (count=0, pointers zeroed), `fetch_pc`=redirect_pc[31:2], stop→0; if a request is outstanding and its response does not arrive this same cycle, drop→1; a response arriving in the redirect cycle is discarded. Any dequeue in that cycle still counts (head was consumed) and may set halted. No request issued in the redirect cycle.
- Once halted=1, `inst_valid` is forced 0 and no further requests are issued; only reset clears it.
- `imem_valid` with outstanding=0 is a protocol error: ignored.

## Timing
- Request-to-visible latency: response at cycle t → `inst_valid` at t+1 (registered queue, head outputs decoded from storage).
- Redirect at cycle t → first new `imem_req` at t+1 if nothing outstanding, else the cycle after the discarded response.
- Steady state with 1-cycle memory: one instruction every 2 cycles (req, resp).
- `halted` rises the cycle after the zero word is accepted.
- Reset mid-request: outstanding cleared; a late `imem_valid` after reset is ignored per the protocol-error rule.

## Test plan
- Reset, memory returns 0x20020005, 0x20030007, 0x00000000 at words 0,1,2 with 1-cycle latency, `inst_ready`=1 → `inst_pc` sequence 0x0,0x4,0x8; no request for word 3; `halted`=1 one cycle after 0x0 accepted.
- `inst_ready`=0 with DEPTH=4, nonzero words → exactly 4 requests, `imem_req` then stays 0; raise `inst_ready` → 4 words drain in order, fetching resumes at PC 0x10.
- Redirect to 0x00000043 while request to 0x8 outstanding, response 3 cycles later → response discarded, next `imem_addr`=0x10 (PC 0x40), queue empty in between.
- Redirect in the same cycle as a response → word not enqueued, count=0, drop=0 after.
- Zero word enqueued then redirect before it is consumed → halted stays 0, fetching resumes at redirect target.
- `reset` low for one cycle mid-stream → all outputs return to reset values, fetch restarts at RESET_PC.
